voice_ctrl_mapper: RTL

Parametrised successor to the fixed 2048-sample volume averager and threshold logic. It consumes signed PCM samples from the audio recorder and produces a per-window mean absolute volume. From that volume it derives game controls:
- run, with hysteresis;
- a multi-level run speed;
- a jump event, triggered by a sudden volume rise, with a cooldown.

It sits between the recorder and the game logic in the top-level control.

---
 rtl/voice_ctrl_pkg.sv | 30 +++
 rtl/voice_ctrl_mapper_window_averager.sv | 111 +++++++++++
 rtl/voice_ctrl_mapper.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/voice_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// voice_ctrl_pkg
// Shared definitions for the voice control mapper:
//   state_t  - control FSM states reported on o_state
//   SPEED_W  - width of the speed and jump-height outputs
//   abs_sat  - saturating magnitude of a signed sample
// ---------------------------------------------------------------------------
package voice_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEED  = 2'd1,
    S_ARMED = 2'd2,
    S_COOL  = 2'd3
  } state_t;

  localparam int SPEED_W = 16;

  // Magnitude of a sign-extended sample of width dw (dw <= 31).
  // The most negative value has no positive counterpart, so it is clamped
  // to the largest positive value of that width.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int dw);
    logic [31:0] lim;
    logic [31:0] mag;
    lim = (32'd1 << (dw - 1)) - 32'd1;
    mag = x[31] ? 32'(-x) : 32'(x);
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/voice_ctrl_mapper_window_averager.sv
// ---------------------------------------------------------------------------
// window_averager
// Converts signed samples to magnitudes, accumulates 2^LOG2_WIN accepted
// samples and publishes the scaled mean once per window.
//
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_start       enable; low discards the partial window
//   i_valid       sample strobe (accepted only while i_start=1)
//   i_data        signed sample
//   o_win_end     combinational: this cycle's sample closes a window
//   o_win_avg     combinational: volume of the window closing this cycle
//   o_avg_valid   registered one-cycle publish pulse
//   o_avg_vol     registered latest window volume (holds between windows)
//   o_peak_vol    (VOICE_PEAK_EN only) per-window peak magnitude, same scale
// ---------------------------------------------------------------------------
module window_averager
  import voice_ctrl_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LOG2_WIN = 11,
  parameter int AVG_W    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_win_end,
  output logic [AVG_W-1:0]         o_win_avg,
  output logic                     o_avg_valid,
  output logic [AVG_W-1:0]         o_avg_vol
`ifdef VOICE_PEAK_EN
  ,
  output logic [AVG_W-1:0]         o_peak_vol
`endif
);

  localparam int MAG_W = DATA_W - 1;
  localparam int ACC_W = MAG_W + LOG2_WIN;

  logic [31:0]         mag_full;
  logic [MAG_W-1:0]    mag;
  logic                unused_mag_hi;
  logic [ACC_W-1:0]    acc_reg;
  logic [ACC_W-1:0]    acc_sum;
  logic [LOG2_WIN-1:0] cnt_reg;
  logic                accept;
  logic                last;

  assign mag_full      = abs_sat(32'(i_data), DATA_W);
  assign mag           = mag_full[MAG_W-1:0];
  assign unused_mag_hi = ^mag_full[31:MAG_W];

  assign accept  = i_start & i_valid;
  assign last    = (cnt_reg == {LOG2_WIN{1'b1}});
  assign acc_sum = acc_reg + ACC_W'(mag);

  // Mean is acc_sum >> LOG2_WIN; scaling down to AVG_W keeps its top bits,
  // so the published volume is simply the top AVG_W bits of the sum.
  assign o_win_end = accept & last;
  assign o_win_avg = acc_sum[ACC_W-1 -: AVG_W];

`ifdef VOICE_PEAK_EN
  logic [MAG_W-1:0] peak_reg;
  logic [MAG_W-1:0] peak_max;
  assign peak_max = (mag > peak_reg) ? mag : peak_reg;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      o_avg_valid <= 1'b0;
      o_avg_vol   <= '0;
`ifdef VOICE_PEAK_EN
      peak_reg    <= '0;
      o_peak_vol  <= '0;
`endif
    end else begin
      o_avg_valid <= 1'b0;
      if (!i_start) begin
        // Leaving the active level throws away the partial window.
        acc_reg  <= '0;
        cnt_reg  <= '0;
`ifdef VOICE_PEAK_EN
        peak_reg <= '0;
`endif
      end else if (i_valid) begin
        if (last) begin
          // Closing sample belongs to the old window; restart immediately.
          acc_reg     <= '0;
          cnt_reg     <= '0;
          o_avg_valid <= 1'b1;
          o_avg_vol   <= o_win_avg;
`ifdef VOICE_PEAK_EN
          peak_reg    <= '0;
          o_peak_vol  <= peak_max[MAG_W-1 -: AVG_W];
`endif
        end else begin
          acc_reg  <= acc_sum;
          cnt_reg  <= cnt_reg + LOG2_WIN'(1);
`ifdef VOICE_PEAK_EN
          peak_reg <= peak_max;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/voice_ctrl_mapper.sv
// ---------------------------------------------------------------------------
// voice_ctrl_mapper
// Turns windowed microphone volume into game controls: run (with
// hysteresis), a multi-level run speed and a rise-triggered jump with a
// per-window cooldown.
//
// Optional feature macro: VOICE_PEAK_EN adds o_peak_vol (per-window peak,
// same scaling as o_avg_vol, published with o_avg_valid).
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_start        level enable; low returns to S_IDLE
//   i_valid        sample strobe
//   i_data         signed PCM sample
//   o_avg_valid    one-cycle pulse per published window
//   o_avg_vol      latest window volume
//   o_run          run flag
//   o_run_speed    BASE_SPEED + level while running, else 0
//   o_jump         one-cycle jump pulse, coincident with o_avg_valid
//   o_jump_height  volume rise that caused the last jump
//   o_state        FSM state (voice_ctrl_pkg::state_t)
// ---------------------------------------------------------------------------
module voice_ctrl_mapper
  import voice_ctrl_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LOG2_WIN   = 11,
  parameter int AVG_W      = 8,
  parameter int RUN_ON     = 30,
  parameter int RUN_OFF    = 25,
  parameter int LEVEL_STEP = 15,
  parameter int N_LEVELS   = 3,
  parameter int BASE_SPEED = 2,
  parameter int JUMP_DELTA = 20,
  parameter int COOL_WIN   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_avg_valid,
  output logic [AVG_W-1:0]         o_avg_vol,
  output logic                     o_run,
  output logic [SPEED_W-1:0]       o_run_speed,
  output logic                     o_jump,
  output logic [SPEED_W-1:0]       o_jump_height,
  output logic [1:0]               o_state
`ifdef VOICE_PEAK_EN
  ,
  output logic [AVG_W-1:0]         o_peak_vol
`endif
);

  localparam int EXT_W  = AVG_W + 4;
  localparam int COOL_W = (COOL_WIN < 1) ? 1 : $clog2(COOL_WIN + 1);

  localparam logic [EXT_W-1:0] RUN_ON_X  = EXT_W'(RUN_ON);
  localparam logic [EXT_W-1:0] RUN_OFF_X = EXT_W'(RUN_OFF);

  logic             win_end;
  logic [AVG_W-1:0] win_avg;

  window_averager #(
    .DATA_W  (DATA_W),
    .LOG2_WIN(LOG2_WIN),
    .AVG_W   (AVG_W)
  ) u_avg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_win_end  (win_end),
    .o_win_avg  (win_avg),
    .o_avg_valid(o_avg_valid),
    .o_avg_vol  (o_avg_vol)
`ifdef VOICE_PEAK_EN
    ,
    .o_peak_vol (o_peak_vol)
`endif
  );

  state_t             state_reg;
  logic               run_reg;
  logic [SPEED_W-1:0] speed_reg;
  logic               jump_reg;
  logic [SPEED_W-1:0] height_reg;
  logic [AVG_W-1:0]   prev_reg;
  logic [COOL_W-1:0]  cool_reg;

  logic [EXT_W-1:0]   avg_ext;
  logic               run_next;
  logic [7:0]         lvl_hit;
  logic [3:0]         level;
  logic [SPEED_W-1:0] speed_lvl;
  logic [AVG_W:0]     prev_plus;
  logic               jump_hit;

  assign avg_ext = EXT_W'(win_avg);

  // Hysteresis: on at RUN_ON, off only below RUN_OFF.
  always_comb begin
    run_next = run_reg;
    if (!run_reg && (avg_ext >= RUN_ON_X)) begin
      run_next = 1'b1;
    end else if (run_reg && (avg_ext < RUN_OFF_X)) begin
      run_next = 1'b0;
    end
  end

  // One comparator per level above 0; the level is the count of hits.
  assign lvl_hit[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_level
      if (gi < N_LEVELS) begin : g_used
        localparam logic [EXT_W-1:0] THR = EXT_W'(RUN_ON + gi * LEVEL_STEP);
        assign lvl_hit[gi] = (avg_ext >= THR);
      end else begin : g_unused
        assign lvl_hit[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    level = 4'd0;
    for (int k = 1; k < 8; k++) begin
      level = level + {3'b000, lvl_hit[k]};
    end
  end

  assign speed_lvl = SPEED_W'(BASE_SPEED) + SPEED_W'(level);

  // One extra bit so prev + delta never wraps below the threshold.
  assign prev_plus = {1'b0, prev_reg} + (AVG_W + 1)'(JUMP_DELTA);
  assign jump_hit  = ({1'b0, win_avg} >= prev_plus);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= S_IDLE;
      run_reg    <= 1'b0;
      speed_reg  <= '0;
      jump_reg   <= 1'b0;
      height_reg <= '0;
      prev_reg   <= '0;
      cool_reg   <= '0;
    end else begin
      jump_reg <= 1'b0;
      if (!i_start) begin
        // Volume and last jump height are kept for the game logic.
        state_reg <= S_IDLE;
        run_reg   <= 1'b0;
        speed_reg <= '0;
        cool_reg  <= '0;
      end else begin
        if (win_end) begin
          prev_reg  <= win_avg;
          run_reg   <= run_next;
          speed_reg <= run_next ? speed_lvl : '0;
        end
        case (state_reg)
          S_IDLE: state_reg <= S_SEED;
          S_SEED: if (win_end) state_reg <= S_ARMED;
          S_ARMED: begin
            if (win_end && jump_hit) begin
              jump_reg   <= 1'b1;
              height_reg <= SPEED_W'(win_avg - prev_reg);
              cool_reg   <= COOL_W'(COOL_WIN);
              state_reg  <= S_COOL;
            end
          end
          S_COOL: begin
            if (win_end) begin
              // Re-arm on the window that brings the counter to zero.
              if (cool_reg <= COOL_W'(1)) begin
                cool_reg  <= '0;
                state_reg <= S_ARMED;
              end else begin
                cool_reg <= cool_reg - COOL_W'(1);
              end
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign o_run         = run_reg;
  assign o_run_speed   = speed_reg;
  assign o_jump        = jump_reg;
  assign o_jump_height = height_reg;
  assign o_state       = state_reg;

endmodule
